uart_rx_byte: RTL and testbench

UART_RX_BYTE -- requirements
Module: uart_rx_byte

---
 rtl/uart_rx_byte.sv | 159 +++++++++++++++
 tb/tb_uart_rx_byte.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver for one byte per frame.
// The incoming line is synchronized with two flops. Each bit is sampled at
// its middle, timed by a counter of CLKS_PER_BIT clock cycles. A good frame
// updates rx_out and pulses data_valid. A frame whose stop bit is low pulses
// frame_err once, and the receiver then waits for the line to return high.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       rx_in,
    output logic [7:0] rx_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    // Counter value at the end of one full bit period.
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    // Counter value at the middle of the start bit.
    localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } state_t;

    logic          r_sync1;
    logic          r_sync2;
    logic          w_rx_s;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_rx_out;
    logic          r_data_valid;
    logic          r_frame_err;
    logic          r_busy;

    // Two-flop synchronizer. Both flops reset to the idle-high line level,
    // so leaving reset never looks like a start edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            // NOTE: use non-blocking assignments in clocked blocks. With blocking
            // assignments, both flops would take rx_in on the same edge and the
            // synchronizer would act as a single flop.
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    // Receive FSM. State, counters, data and all outputs are registered here.
    // busy is updated on the same edge as the state, so it always equals (state != IDLE).
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_rx_out     <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            // The event pulses are low unless a stop sample raises one of them below.
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;

            unique case (r_state)
                ST_IDLE: begin
                    if (!w_rx_s) begin
                        r_cnt   <= '0;
                        r_state <= ST_START;
                        r_busy  <= 1'b1;
                    end
                end

                ST_START: begin
                    if (r_cnt == HALF_CNT) begin
                        if (!w_rx_s) begin
                            r_cnt     <= '0;
                            r_bit_idx <= '0;
                            r_state   <= ST_DATA;
                        end else begin
                            // The line went back high before mid-bit, so this was a glitch.
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                ST_DATA: begin
                    if (r_cnt == LAST_CNT) begin
                        r_cnt   <= '0;
                        // The line sends the LSB first, so each new bit enters at bit 7.
                        r_shift <= {w_rx_s, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                ST_STOP: begin
                    if (r_cnt == LAST_CNT) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_rx_out     <= r_shift;
                            r_data_valid <= 1'b1;
                            r_state      <= ST_IDLE;
                            r_busy       <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_WAIT_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                ST_WAIT_HIGH: begin
                    // A break holds the line low. Stay here so the break reports
                    // only one framing error.
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_out     = r_rx_out;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Testbench for uart_rx_byte (CLKS_PER_BIT = 16).
// The stimulus side serializes 8N1 frames. For each frame it queues the event
// the receiver should report: a byte, or a framing error that leaves the last
// good byte on rx_out. A monitor pops one queued event for each output pulse.
module tb_uart_rx_byte;

    localparam int CPB = 16;

    logic       CLK   = 1'b0;
    logic       RST_N = 1'b0;
    logic       rx_in = 1'b1;
    logic [7:0] rx_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .rx_in      (rx_in),
        .rx_out     (rx_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        mon_e;
    logic [7:0] last_good = 8'h00;
    int         exp_valid_total = 0;
    int         exp_ferr_total  = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         n_valid  = 0;
    int         n_ferr   = 0;
    int         last_valid_cyc = 0;
    logic       prev_dv = 1'b0;
    logic       prev_fe = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every output pulse must match the oldest expected event.
    always @(negedge CLK) begin
        if (!RST_N) begin
            prev_dv = 1'b0;
            prev_fe = 1'b0;
        end else begin
            if (prev_dv) begin
                check("dv_one_cycle", data_valid, 0);
                check("busy_after_valid", busy, 0);
            end
            if (prev_fe) check("fe_one_cycle", frame_err, 0);
            if (data_valid || frame_err) begin
                check("dv_fe_exclusive", data_valid & frame_err, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {data_valid, frame_err}, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check(mon_e.is_err ? "frame_err_event" : "data_valid_event",
                          frame_err, mon_e.is_err);
                    check("rx_out_at_event", rx_out, mon_e.data);
                end
            end
            if (data_valid) begin
                n_valid++;
                last_valid_cyc = cyc;
            end
            if (frame_err) n_ferr++;
            prev_dv = data_valid;
            prev_fe = frame_err;
        end
    end

    // Holds the line at v for n bit periods. Call it just after a rising edge.
    task automatic drive_bits(input logic v, input int n);
        rx_in = v;
        repeat (n * CPB) @(posedge CLK);
        #1;
    endtask

    // Sends one frame and queues the event the receiver should report for it.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok, output int start_cyc);
        ev_t e;
        e.is_err = !stop_ok;
        if (stop_ok) begin
            e.data    = b;
            last_good = b;
            exp_valid_total++;
        end else begin
            e.data = last_good;
            exp_ferr_total++;
        end
        exp_q.push_back(e);
        start_cyc = cyc;
        drive_bits(1'b0, 1);
        for (int i = 0; i < 8; i++) drive_bits(b[i], 1);
        drive_bits(stop_ok, 1);
    endtask

    // Waits, with a cycle limit, until the monitor has consumed every expected event.
    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   sc;
        int   v0;
        int   f0;
        logic bseen;
        logic [7:0] b;
        logic ok;

        // Reset held low with the line toggling: every output stays at zero.
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            check("reset_outputs", {rx_out, data_valid, frame_err, busy}, 0);
            rx_in = 1'($urandom_range(0, 1));
        end
        rx_in = 1'b1;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        drive_bits(1'b1, 2);
        check("idle_after_reset", {rx_out, busy}, 0);

        // A single 0xA5 frame. Check its latency from the start edge.
        send_frame(8'hA5, 1'b1, sc);
        drain("drain_a5");
        check("a5_latency_max", (last_valid_cyc - sc) <= (9 * CPB + CPB / 2 + 3), 1);
        check("a5_latency_min", (last_valid_cyc - sc) >= (9 * CPB), 1);
        check("a5_rx_out", rx_out, 8'hA5);
        check("a5_busy_low", busy, 0);
        drive_bits(1'b1, 1);

        // Frames 0x00 and 0xFF sent back to back with no idle gap.
        v0 = n_valid;
        f0 = n_ferr;
        send_frame(8'h00, 1'b1, sc);
        send_frame(8'hFF, 1'b1, sc);
        drain("drain_b2b");
        check("b2b_valid_count", n_valid - v0, 2);
        check("b2b_no_frame_err", n_ferr - f0, 0);
        check("b2b_rx_out", rx_out, 8'hFF);
        drive_bits(1'b1, 1);

        // A 3-cycle low glitch on the line must not produce any event.
        v0    = n_valid;
        f0    = n_ferr;
        bseen = 1'b0;
        rx_in = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        rx_in = 1'b1;
        repeat (30) begin
            @(negedge CLK);
            if (busy) bseen = 1'b1;
        end
        @(posedge CLK);
        #1;
        check("glitch_busy_seen", bseen, 1);
        check("glitch_busy_idle", busy, 0);
        check("glitch_no_valid", n_valid - v0, 0);
        check("glitch_no_frame_err", n_ferr - f0, 0);

        // 0xA5, then 0x3C with a low stop bit while the line is held low
        // (a break), then 0x55.
        send_frame(8'hA5, 1'b1, sc);
        v0 = n_valid;
        f0 = n_ferr;
        send_frame(8'h3C, 1'b0, sc);
        drive_bits(1'b0, 10);
        check("break_busy_high", busy, 1);
        drive_bits(1'b0, 10);
        drain("drain_break");
        check("break_one_frame_err", n_ferr - f0, 1);
        check("break_no_valid", n_valid - v0, 0);
        check("break_rx_out_held", rx_out, 8'hA5);
        drive_bits(1'b1, 2);
        send_frame(8'h55, 1'b1, sc);
        drain("drain_55");
        check("after_break_rx_out", rx_out, 8'h55);

        // Reset pulsed in the middle of data bit 4. The partial frame is
        // dropped, then 0x81 is received.
        v0 = n_valid;
        f0 = n_ferr;
        b  = 8'h6B;
        drive_bits(1'b0, 1);
        for (int i = 0; i < 4; i++) drive_bits(b[i], 1);
        rx_in = b[4];
        repeat (CPB / 2) @(posedge CLK);
        #1;
        check("busy_in_data", busy, 1);
        #1;
        RST_N = 1'b0;
        rx_in = 1'b1;
        #1;
        check("reset_mid_outputs", {rx_out, data_valid, frame_err, busy}, 0);
        repeat (3) @(posedge CLK);
        #1;
        RST_N     = 1'b1;
        last_good = 8'h00;
        drive_bits(1'b1, 12);
        check("aborted_no_pulse", (n_valid - v0) + (n_ferr - f0), 0);
        check("aborted_rx_out", rx_out, 8'h00);
        send_frame(8'h81, 1'b1, sc);
        drain("drain_81");
        check("after_reset_rx_out", rx_out, 8'h81);
        check("after_reset_one_valid", n_valid - v0, 1);

        // Random frames with random gaps and an occasional bad stop bit.
        for (int k = 0; k < 40; k++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 9) != 0);
            send_frame(b, ok, sc);
            if (!ok) begin
                drive_bits(1'b0, int'($urandom_range(0, 3)));
                drive_bits(1'b1, 1);
            end else begin
                drive_bits(1'b1, int'($urandom_range(0, 2)));
            end
        end
        drain("drain_random");
        drive_bits(1'b1, 2);

        check("total_valid", n_valid, exp_valid_total);
        check("total_frame_err", n_ferr, exp_ferr_total);
        check("final_rx_out", rx_out, last_good);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
